proj_frag_fetch_arbiter: RTL and testbench
==========================================

Name: proj_frag_fetch_arbiter

Overview:
- Shares one single-port, word-organised reference memory between N_REQ extender lanes.
- Each lane asks for a FRAG_LEN-bit window at a signed bit index.
- The block arbitrates round-robin, fetches one or two memory words, zero-pads any bits outside the memory, and returns the assembled fragment to the requesting lane.
- It sits between the proj_extender instances and the external reference memory.

Parameters:
- N_REQ, 2, number of requesting lanes.
- FRAG_LEN, 8, fragment width in bits; must be <= MEM_WIDTH.
- MEM_WIDTH, 32, memory word width in bits; must be a power of two.
- MEM_DEPTH, 32, number of memory words.
- IDX_LEN, 11, width of the signed bit index. It covers ±(MEM_WIDTH*MEM_DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-lane request; held until accepted.
- req_index  in  N_REQ x IDX_LEN (signed)  per-lane start bit index.
- req_ready  out  N_REQ  one-hot accept strobe; a transfer happens when req_valid[i] & req_ready[i].
- rsp_valid  out  N_REQ  one-hot, one-cycle response strobe.
- rsp_fragment  out  FRAG_LEN  fragment for the lane flagged in rsp_valid.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  $clog2(MEM_DEPTH)  memory word address.
- mem_rd_data  in  MEM_WIDTH  read data, valid the cycle after mem_rd_en.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - rsp_valid=0, rsp_fragment=0, mem_rd_en=0, mem_rd_addr=0, busy=0.
  - Round-robin pointer set to N_REQ-1, so lane 0 has highest priority next.
  - req_ready is 0 while rst=1.
- States: IDLE -> RD_LO -> RD_HI -> ASM -> IDLE. One transaction is outstanding at a time.
- IDLE:
  - req_ready is combinational.
  - Grant goes to the first lane with req_valid=1, searching cyclically from pointer+1.
  - On accept (cycle T):
    - Capture the index and the lane id.
    - Set pointer = granted lane.
    - Go to RD_LO.
  - With no valid request, stay in IDLE.
- Address math:
  - w0 = index >>> log2(MEM_WIDTH) (arithmetic shift, floor).
  - off = index mod MEM_WIDTH (low bits of index).
  - w1 = w0+1.
  - A word is in range iff 0 <= w < MEM_DEPTH.
- RD_LO (T+1): mem_rd_en=1 with addr=w0 only if w0 is in range; otherwise mem_rd_en=0.
- RD_HI (T+2):
  - Latch lo = mem_rd_data if w0 was read, else 0.
  - mem_rd_en=1 with addr=w1 only if off+FRAG_LEN > MEM_WIDTH and w1 is in range.
- ASM (T+3):
  - Latch hi = mem_rd_data if w1 was read, else 0.
  - Register rsp_fragment = ({hi,lo} >> off)[FRAG_LEN-1:0].
  - Set rsp_valid[lane]=1 for the following cycle.
  - Go to IDLE.
- Response timing:
  - rsp_valid pulses in cycle T+4 (fixed latency 4), whether 0, 1 or 2 reads were needed.
  - rsp_fragment holds its value until the next response.
- Back-to-back: in cycle T+4 the state is IDLE, so a new accept may coincide with the rsp_valid pulse. Maximum throughput is one fragment per 4 cycles.
- Padding: every fragment bit whose absolute bit address index+i lies outside [0, MEM_WIDTH*MEM_DEPTH) is 0. Memory is never read at an out-of-range address.
- mem_rd_addr holds its last value when mem_rd_en=0.
- Reset mid-transaction: the transaction is dropped and no rsp_valid is produced. The lane must re-request.
- A lane may deassert req_valid before acceptance; this is legal and the lane is simply not granted.

Decomposition:
- Shared package: add the following to proj_pkg.
  - MEM_WIDTH and MEM_DEPTH defaults.
  - fetch_state_t enum {IDLE, RD_LO, RD_HI, ASM}.
  - Function frag_word_in_range(signed w).
- Sub-module: proj_rr_arbiter (N_REQ; inputs req and pointer; output one-hot grant). It is combinational and reusable for other shared resources.

Test Plan:
- Memory preload for all tests: every byte of word k = k ^ 8'h5A.
- 1. Lane 0 requests index 168 -> req_ready[0] in cycle T; one read at addr 5 in T+1; rsp_valid=2'b01 with fragment 0x5F in T+4.
- 2. Straddle, lane 1 requests index 124 -> reads at addr 3 (T+1) and addr 4 (T+2); rsp_valid=2'b10 with fragment 0xE5 in T+4.
- 3. Edges:
  - index -4 -> one read at addr 0, fragment 0xA0.
  - index -8 -> no reads, fragment 0x00.
  - index 1020 -> one read at addr 31, fragment 0x04.
  - All at latency 4.
- 4. Both lanes hold req_valid continuously after reset -> grants 0,1,0,1 at cycles 0,4,8,12; rsp_valid alternates 01,10,01,10.
- 5. rst=1 in the RD_HI cycle of a lane-1 request:
  - No rsp_valid.
  - mem_rd_en=0 and busy=0 on the next cycle.
  - With both lanes then valid, lane 0 is granted first.
- 6. Lane 0 re-requests (index 0) in the same cycle its rsp_valid pulses -> accepted in that cycle; fragment 0x5A arrives 4 cycles later.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared definitions for the projection datapath.
// Holds the default reference-memory geometry, the fetch FSM state type and
// a helper used when deciding whether a computed word address may be read.
package proj_pkg;

  localparam int DEFAULT_MEM_WIDTH = 32;
  localparam int DEFAULT_MEM_DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_LO,
    RD_HI,
    ASM
  } fetch_state_t;

  // True when a signed word address lands inside the memory.
  function automatic logic frag_word_in_range(input logic signed [31:0] w,
                                              input int depth);
    return (w >= 0) && (w < depth);
  endfunction

endpackage

// File: rtl/proj_frag_fetch_arbiter_if.sv
// Bus between the extender lanes / reference memory and the fragment fetch
// arbiter.
//   req_valid    lanes -> arbiter   per-lane request, held until accepted
//   req_index    lanes -> arbiter   per-lane signed start bit index
//   req_ready    arbiter -> lanes   one-hot accept strobe
//   rsp_valid    arbiter -> lanes   one-hot one-cycle response strobe
//   rsp_fragment arbiter -> lanes   fragment for the flagged lane
//   mem_rd_en    arbiter -> memory  read enable
//   mem_rd_addr  arbiter -> memory  word address
//   mem_rd_data  memory -> arbiter  read data, one cycle after mem_rd_en
// slave is the arbiter side, master is the lanes + memory side.
interface proj_frag_fetch_arbiter_if
  import proj_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int FRAG_LEN  = 8,
  parameter int MEM_WIDTH = DEFAULT_MEM_WIDTH,
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int IDX_LEN   = 11
);

  localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [N_REQ-1:0]               req_valid;
  logic [N_REQ-1:0][IDX_LEN-1:0]  req_index;
  logic [N_REQ-1:0]               req_ready;
  logic [N_REQ-1:0]               rsp_valid;
  logic [FRAG_LEN-1:0]            rsp_fragment;
  logic                           mem_rd_en;
  logic [ADDR_W-1:0]              mem_rd_addr;
  logic [MEM_WIDTH-1:0]           mem_rd_data;

  modport slave (
    input  req_valid, req_index, mem_rd_data,
    output req_ready, rsp_valid, rsp_fragment, mem_rd_en, mem_rd_addr
  );

  modport master (
    output req_valid, req_index, mem_rd_data,
    input  req_ready, rsp_valid, rsp_fragment, mem_rd_en, mem_rd_addr
  );

endinterface

// File: rtl/proj_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      in   N_REQ   request vector
//   pointer  in   PTR_W   last granted lane; search starts at pointer+1
//   grant    out  N_REQ   one-hot grant (all zero when nothing requests)
// The caller owns the pointer register, so this block can be reused for any
// shared resource with its own update policy.
module proj_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N_REQ-1:0] grant
);

  int   idx;
  logic found;

  // Walk the lanes cyclically starting just after the pointer; first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(pointer) + k) % N_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/proj_frag_fetch_arbiter.sv
// Fragment fetch arbiter: shares one single-port word memory between N_REQ
// extender lanes. Each accepted request reads up to two words and returns a
// zero-padded FRAG_LEN-bit window with a fixed latency of four cycles.
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   bus   slave modport of proj_frag_fetch_arbiter_if (requests, responses,
//         memory read port)
//   busy  out  high whenever the fetch FSM is not IDLE
module proj_frag_fetch_arbiter
  import proj_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int FRAG_LEN  = 8,
  parameter int MEM_WIDTH = DEFAULT_MEM_WIDTH,
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int IDX_LEN   = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  proj_frag_fetch_arbiter_if.slave   bus,
  output logic                       busy
);

  localparam int OFF_W  = $clog2(MEM_WIDTH);
  localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  fetch_state_t               state;
  logic [PTR_W-1:0]           ptr;
  logic [PTR_W-1:0]           lane;
  logic signed [IDX_LEN-1:0]  idx_q;
  logic [MEM_WIDTH-1:0]       lo;
  logic                       rd_lo_q;
  logic                       rd_hi_q;

  logic [N_REQ-1:0]           grant;
  logic [PTR_W-1:0]           gnt_id;
  logic signed [IDX_LEN-1:0]  gnt_index;
  logic signed [31:0]         new_w0;
  logic signed [31:0]         w0;
  logic signed [31:0]         w1;
  logic [OFF_W-1:0]           off;
  logic                       lo_ok;
  logic                       hi_ok;
  logic [MEM_WIDTH-1:0]       hi_v;
  logic [FRAG_LEN-1:0]        frag_next;

  proj_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req     (bus.req_valid),
    .pointer (ptr),
    .grant   (grant)
  );

  // Accepts only happen in IDLE, and never while reset is asserted.
  assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;
  assign busy          = (state != IDLE);

  // Turn the one-hot grant into a lane number and pick that lane's index.
  always_comb begin
    gnt_id    = '0;
    gnt_index = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_id    = PTR_W'(i);
        gnt_index = $signed(bus.req_index[i]);
      end
    end
  end

  // Word/offset split. The arithmetic shift floors negative indices so that
  // e.g. index -4 maps to word -1 with offset 28, letting the upper bits of
  // the window come from word 0 while the lower ones pad with zeros.
  always_comb begin
    new_w0    = $signed(32'(gnt_index)) >>> OFF_W;
    w0        = $signed(32'(idx_q)) >>> OFF_W;
    w1        = w0 + 32'sd1;
    off       = idx_q[OFF_W-1:0];
    lo_ok     = frag_word_in_range(new_w0, MEM_DEPTH);
    hi_ok     = ((int'(off) + FRAG_LEN) > MEM_WIDTH) &&
                frag_word_in_range(w1, MEM_DEPTH);
    hi_v      = rd_hi_q ? bus.mem_rd_data : '0;
    frag_next = FRAG_LEN'({hi_v, lo} >> off);
  end

  // Fetch FSM. Memory controls are registered one state ahead so that the
  // read issued for a state is visible on the bus during that state; words
  // that were not read contribute zeros, which gives the edge padding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ptr              <= PTR_W'(N_REQ - 1);
      lane             <= '0;
      idx_q            <= '0;
      lo               <= '0;
      rd_lo_q          <= 1'b0;
      rd_hi_q          <= 1'b0;
      bus.rsp_valid    <= '0;
      bus.rsp_fragment <= '0;
      bus.mem_rd_en    <= 1'b0;
      bus.mem_rd_addr  <= '0;
    end else begin
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|grant) begin
            idx_q         <= gnt_index;
            lane          <= gnt_id;
            ptr           <= gnt_id;
            rd_lo_q       <= lo_ok;
            bus.mem_rd_en <= lo_ok;
            if (lo_ok) begin
              bus.mem_rd_addr <= new_w0[ADDR_W-1:0];
            end
            state <= RD_LO;
          end
        end
        RD_LO: begin
          rd_hi_q       <= hi_ok;
          bus.mem_rd_en <= hi_ok;
          if (hi_ok) begin
            bus.mem_rd_addr <= w1[ADDR_W-1:0];
          end
          state <= RD_HI;
        end
        RD_HI: begin
          bus.mem_rd_en <= 1'b0;
          lo            <= rd_lo_q ? bus.mem_rd_data : '0;
          state         <= ASM;
        end
        ASM: begin
          bus.rsp_fragment <= frag_next;
          bus.rsp_valid    <= N_REQ'(1) << lane;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proj_frag_fetch_arbiter.sv
// Directed bench for proj_frag_fetch_arbiter. Memory word k holds the byte
// k ^ 8'h5A in every byte lane; expected fragments are worked out by hand.
module tb_proj_frag_fetch_arbiter;

  localparam int N_REQ     = 2;
  localparam int FRAG_LEN  = 8;
  localparam int MEM_WIDTH = 32;
  localparam int MEM_DEPTH = 32;
  localparam int IDX_LEN   = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  proj_frag_fetch_arbiter_if #(
    .N_REQ(N_REQ), .FRAG_LEN(FRAG_LEN), .MEM_WIDTH(MEM_WIDTH),
    .MEM_DEPTH(MEM_DEPTH), .IDX_LEN(IDX_LEN)
  ) bus ();

  proj_frag_fetch_arbiter #(
    .N_REQ(N_REQ), .FRAG_LEN(FRAG_LEN), .MEM_WIDTH(MEM_WIDTH),
    .MEM_DEPTH(MEM_DEPTH), .IDX_LEN(IDX_LEN)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  // Drives one request starting at the next cycle (T) and records what the
  // DUT shows in cycles T..T+4. Comparisons are made by the calling test.
  task automatic do_request(input int lane, input logic signed [10:0] idx,
                            output logic rdy, output logic en1, output logic [4:0] a1,
                            output logic en2, output logic [4:0] a2, output logic en3,
                            output logic [1:0] early_rv, output logic busy1,
                            output logic [1:0] rv4, output logic [7:0] frag4);
    @(posedge clk); #1;
    bus.req_valid[lane] = 1'b1;
    bus.req_index[lane] = idx;
    #1 rdy = bus.req_ready[lane];
    @(posedge clk); #1;
    bus.req_valid[lane] = 1'b0;
    #1 en1 = bus.mem_rd_en; a1 = bus.mem_rd_addr; early_rv = bus.rsp_valid; busy1 = busy;
    @(posedge clk); #2;
    en2 = bus.mem_rd_en; a2 = bus.mem_rd_addr; early_rv |= bus.rsp_valid;
    @(posedge clk); #2;
    en3 = bus.mem_rd_en; early_rv |= bus.rsp_valid;
    @(posedge clk); #2;
    rv4 = bus.rsp_valid; frag4 = bus.rsp_fragment;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_index = '0;
    @(posedge clk); @(posedge clk); #2;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
    checks++; if (bus.rsp_fragment !== 8'h00) begin errors++; $display("[TB] FAIL reset_fragment: got %h expected 00", bus.rsp_fragment); end
    checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %b expected 0", bus.mem_rd_en); end
    checks++; if (bus.mem_rd_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd_addr: got %0d expected 0", bus.mem_rd_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    bus.req_valid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic rdy, en1, en2, en3, busy1; logic [4:0] a1, a2; logic [1:0] erv, rv4; logic [7:0] frag;
    do_request(0, 11'sd168, rdy, en1, a1, en2, a2, en3, erv, busy1, rv4, frag);
    checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", rdy); end
    checks++; if (en1 !== 1'b1 || a1 !== 5'd5) begin errors++; $display("[TB] FAIL single_rd_lo: got en=%b addr=%0d expected en=1 addr=5", en1, a1); end
    checks++; if (en2 !== 1'b0) begin errors++; $display("[TB] FAIL single_rd_hi: got en=%b expected 0", en2); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy1); end
    checks++; if (erv !== 2'b00) begin errors++; $display("[TB] FAIL single_early_rsp: got %b expected 00", erv); end
    checks++; if (rv4 !== 2'b01) begin errors++; $display("[TB] FAIL single_rsp_valid: got %b expected 01", rv4); end
    checks++; if (frag !== 8'h5F) begin errors++; $display("[TB] FAIL single_fragment: got %h expected 5f", frag); end
  endtask

  task automatic test_straddle();
    logic rdy, en1, en2, en3, busy1; logic [4:0] a1, a2; logic [1:0] erv, rv4; logic [7:0] frag;
    do_request(1, 11'sd124, rdy, en1, a1, en2, a2, en3, erv, busy1, rv4, frag);
    checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL straddle_ready: got %b expected 1", rdy); end
    checks++; if (en1 !== 1'b1 || a1 !== 5'd3) begin errors++; $display("[TB] FAIL straddle_rd_lo: got en=%b addr=%0d expected en=1 addr=3", en1, a1); end
    checks++; if (en2 !== 1'b1 || a2 !== 5'd4) begin errors++; $display("[TB] FAIL straddle_rd_hi: got en=%b addr=%0d expected en=1 addr=4", en2, a2); end
    checks++; if (en3 !== 1'b0) begin errors++; $display("[TB] FAIL straddle_rd_asm: got en=%b expected 0", en3); end
    checks++; if (rv4 !== 2'b10) begin errors++; $display("[TB] FAIL straddle_rsp_valid: got %b expected 10", rv4); end
    checks++; if (frag !== 8'hE5) begin errors++; $display("[TB] FAIL straddle_fragment: got %h expected e5", frag); end
  endtask

  task automatic test_edges();
    logic signed [10:0] e_idx  [3] = '{-11'sd4, -11'sd8, 11'sd1020};
    logic               e_en1  [3] = '{1'b0, 1'b0, 1'b1};
    logic [4:0]         e_a1   [3] = '{5'd0, 5'd0, 5'd31};
    logic               e_en2  [3] = '{1'b1, 1'b0, 1'b0};
    logic [4:0]         e_a2   [3] = '{5'd0, 5'd0, 5'd0};
    logic [7:0]         e_frag [3] = '{8'hA0, 8'h00, 8'h04};
    logic rdy, en1, en2, en3, busy1; logic [4:0] a1, a2; logic [1:0] erv, rv4; logic [7:0] frag;
    for (int t = 0; t < 3; t++) begin
      do_request(0, e_idx[t], rdy, en1, a1, en2, a2, en3, erv, busy1, rv4, frag);
      checks++; if (en1 !== e_en1[t] || (e_en1[t] && a1 !== e_a1[t])) begin errors++; $display("[TB] FAIL edge%0d_rd_lo: got en=%b addr=%0d expected en=%b addr=%0d", t, en1, a1, e_en1[t], e_a1[t]); end
      checks++; if (en2 !== e_en2[t] || (e_en2[t] && a2 !== e_a2[t])) begin errors++; $display("[TB] FAIL edge%0d_rd_hi: got en=%b addr=%0d expected en=%b addr=%0d", t, en2, a2, e_en2[t], e_a2[t]); end
      checks++; if (rv4 !== 2'b01 || erv !== 2'b00) begin errors++; $display("[TB] FAIL edge%0d_latency: got early=%b at4=%b expected early=00 at4=01", t, erv, rv4); end
      checks++; if (frag !== e_frag[t]) begin errors++; $display("[TB] FAIL edge%0d_fragment: got %h expected %h", t, frag, e_frag[t]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy, exp_rv;
    logic [7:0] exp_frag;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_index[0] = 11'sd0;
    bus.req_index[1] = 11'sd32;
    bus.req_valid    = 2'b11;
    for (int c = 0; c <= 16; c++) begin
      exp_rdy = (c % 4 == 0) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rv  = (c % 4 == 0 && c > 0) ? ((((c / 4) - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_frag = (exp_rv == 2'b01) ? 8'h5A : 8'h5B;
      #1;
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("[TB] FAIL b2b_ready c%0d: got %b expected %b", c, bus.req_ready, exp_rdy); end
      checks++; if (bus.rsp_valid !== exp_rv) begin errors++; $display("[TB] FAIL b2b_rsp_valid c%0d: got %b expected %b", c, bus.rsp_valid, exp_rv); end
      if (exp_rv != 2'b00) begin
        checks++; if (bus.rsp_fragment !== exp_frag) begin errors++; $display("[TB] FAIL b2b_fragment c%0d: got %h expected %h", c, bus.rsp_fragment, exp_frag); end
      end
      if (c == 16) bus.req_valid = 2'b00;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    // Cycle T: lane 1 alone requests a straddling window.
    bus.req_index[1] = 11'sd124;
    bus.req_valid    = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL rmid_ready: got %b expected 10", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    // T+2 (RD_HI): reset while both lanes ask.
    rst = 1'b1;
    bus.req_index[0] = 11'sd168;
    bus.req_valid    = 2'b11;
    #1;
    checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== 5'd4) begin errors++; $display("[TB] FAIL rmid_rd_hi: got en=%b addr=%0d expected en=1 addr=4", bus.mem_rd_en, bus.mem_rd_addr); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rmid_ready_in_rst: got %b expected 00", bus.req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL rmid_rd_en_after: got %b expected 0", bus.mem_rd_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy_after: got %b expected 0", busy); end
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rmid_regrant: got %b expected 01", bus.req_ready); end
    for (int c = 4; c <= 7; c++) begin
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      #1;
      if (c < 7) begin
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL rmid_no_rsp T+%0d: got %b expected 00", c, bus.rsp_valid); end
      end else begin
        checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_fragment !== 8'h5F) begin errors++; $display("[TB] FAIL rmid_lane0_rsp: got valid=%b frag=%h expected valid=01 frag=5f", bus.rsp_valid, bus.rsp_fragment); end
      end
    end
  endtask

  task automatic test_rerequest();
    @(posedge clk); #1;
    bus.req_index[0] = 11'sd168;
    bus.req_valid    = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rereq_first_ready: got %b expected 01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    // Cycle A+4: response pulse and new request in the same cycle.
    bus.req_index[0] = 11'sd0;
    bus.req_valid    = 2'b01;
    #1;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_fragment !== 8'h5F) begin errors++; $display("[TB] FAIL rereq_first_rsp: got valid=%b frag=%h expected valid=01 frag=5f", bus.rsp_valid, bus.rsp_fragment); end
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rereq_same_cycle_ready: got %b expected 01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_fragment !== 8'h5F) begin errors++; $display("[TB] FAIL rereq_hold: got valid=%b frag=%h expected valid=00 frag=5f", bus.rsp_valid, bus.rsp_fragment); end
    @(posedge clk); @(posedge clk); #2;
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL rereq_early: got %b expected 00", bus.rsp_valid); end
    @(posedge clk); #2;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_fragment !== 8'h5A) begin errors++; $display("[TB] FAIL rereq_second_rsp: got valid=%b frag=%h expected valid=01 frag=5a", bus.rsp_valid, bus.rsp_fragment); end
  endtask

  initial begin
    for (int k = 0; k < MEM_DEPTH; k++) begin
      mem[k] = {4{8'(k) ^ 8'h5A}};
    end
    bus.req_valid   = '0;
    bus.req_index   = '0;
    bus.mem_rd_data = '0;
    test_reset();
    test_single_read();
    test_straddle();
    test_edges();
    test_back_to_back();
    test_reset_mid();
    test_rerequest();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
